jam_param: RTL and testbench

Parametrised job-assignment search engine: for an N×N cost matrix held in an external combinational ROM, enumerates all N! worker→job permutations in lexicographic order and reports the optimum total cost, the number of permutations achieving it, and the first optimal assignment. It succeeds the fixed 8×8 min-cost engine with generic N, cost width, a min/max mode, a Start/Busy/Valid handshake and re-runnable operation. It sits between the cost ROM and the result-reporting logic.

---
 rtl/jam_pkg.sv | 37 +++
 rtl/jam_perm_gen.sv | 125 ++++++++++++
 rtl/jam_param.sv | 203 ++++++++++++++++++++
 tb/tb_jam_param.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/jam_pkg.sv
// jam_pkg: shared definitions for the jam_param assignment search engine.
//   - default parameter constants for the top level
//   - run-level and permutation-generator state encodings
//   - factorial() used to check that the MatchCount width is large enough
package jam_pkg;

  localparam int JAM_N_DEF  = 8;
  localparam int JAM_CW_DEF = 7;
  localparam int JAM_IW_DEF = 3;
  localparam int JAM_SW_DEF = 10;
  localparam int JAM_MW_DEF = 16;

  // Run controller: PIVOT/SUCC/REVERSE all live inside RUN_STEP and are
  // sequenced by the permutation generator.
  typedef enum logic [2:0] {
    RUN_IDLE,
    RUN_SUM,
    RUN_EVAL,
    RUN_STEP,
    RUN_DONE
  } run_state_t;

  typedef enum logic [1:0] {
    GEN_IDLE,
    GEN_PIVOT,
    GEN_SUCC,
    GEN_REVERSE
  } gen_state_t;

  function automatic int factorial(input int n);
    int f;
    f = 1;
    for (int k = 2; k <= n; k++) f = f * k;
    return f;
  endfunction

endpackage

// File: rtl/jam_perm_gen.sv
// jam_perm_gen: holds the current permutation and advances it to its
// lexicographic successor on request.
//
// Ports:
//   clk, rst  clock, synchronous active-high reset
//   init      load the identity permutation (only honoured while idle)
//   step      start advancing to the next permutation (only while idle)
//   perm      current permutation, job of worker w at [w*IW +: IW]
//   done      one-cycle flag in the final cycle of a step; perm updates on
//             the same edge
//   last      with done: no successor exists, perm is left unchanged
//
// state       | meaning
// GEN_IDLE    | waiting for init or step
// GEN_PIVOT   | scanning i downward for perm[i] < perm[i+1]
// GEN_SUCC    | scanning j downward for perm[j] > perm[i], then swap
// GEN_REVERSE | reversing the suffix after i, one pair per cycle
module jam_perm_gen
  import jam_pkg::*;
#(
  parameter int N  = JAM_N_DEF,
  parameter int IW = JAM_IW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            init,
  input  logic            step,
  output logic [N*IW-1:0] perm,
  output logic            done,
  output logic            last
);

  localparam logic [IW-1:0] I_START = IW'(N - 2);
  localparam logic [IW-1:0] J_START = IW'(N - 1);

  gen_state_t    state_q, state_d;
  logic [IW-1:0] perm_q [N];
  logic [IW-1:0] perm_d [N];
  logic [IW-1:0] i_q, i_d;
  logic [IW-1:0] j_q, j_d;
  logic [IW-1:0] lo_q, lo_d;

  for (genvar w = 0; w < N; w++) begin : g_flat
    assign perm[w*IW +: IW] = perm_q[w];
  end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    lo_d    = lo_q;
    perm_d  = perm_q;
    done    = 1'b0;
    last    = 1'b0;
    case (state_q)
      GEN_IDLE: begin
        if (init) begin
          for (int w = 0; w < N; w++) perm_d[w] = IW'(w);
        end else if (step) begin
          state_d = GEN_PIVOT;
          i_d     = I_START;
        end
      end
      GEN_PIVOT: begin
        if (perm_q[i_q] < perm_q[i_q + 1'b1]) begin
          state_d = GEN_SUCC;
          j_d     = J_START;
        end else if (i_q == '0) begin
          done    = 1'b1;
          last    = 1'b1;
          state_d = GEN_IDLE;
        end else begin
          i_d = i_q - 1'b1;
        end
      end
      GEN_SUCC: begin
        // A hit is guaranteed no later than j = i+1.
        if (perm_q[j_q] > perm_q[i_q]) begin
          perm_d[i_q] = perm_q[j_q];
          perm_d[j_q] = perm_q[i_q];
          if (i_q == I_START) begin
            // single-element suffix: nothing to reverse
            done    = 1'b1;
            state_d = GEN_IDLE;
          end else begin
            state_d = GEN_REVERSE;
            lo_d    = i_q + 1'b1;
            j_d     = J_START;
          end
        end else begin
          j_d = j_q - 1'b1;
        end
      end
      GEN_REVERSE: begin
        perm_d[lo_q] = perm_q[j_q];
        perm_d[j_q]  = perm_q[lo_q];
        lo_d = lo_q + 1'b1;
        j_d  = j_q - 1'b1;
        // finish in the cycle of the last useful swap
        if ((lo_q + 1'b1) >= (j_q - 1'b1)) begin
          done    = 1'b1;
          state_d = GEN_IDLE;
        end
      end
      default: state_d = GEN_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= GEN_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      lo_q    <= '0;
      for (int w = 0; w < N; w++) perm_q[w] <= IW'(w);
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      lo_q    <= lo_d;
      perm_q  <= perm_d;
    end
  end

endmodule

// File: rtl/jam_param.sv
// jam_param: exhaustive job-assignment search. Walks all N! permutations in
// lexicographic order, sums Cost from an external combinational ROM, and
// reports the optimum (min or max) total, how many permutations reach it and
// the first permutation that does.
//
// Ports:
//   CLK, RST    clock, synchronous active-high reset
//   Start       run request, sampled only in IDLE
//   MaxMode     0 = minimise, 1 = maximise; latched when Start is accepted
//   W, J        ROM address (worker, job); W=0, J=perm[0] outside SUM
//   Cost        ROM data for (W,J), same cycle
//   Busy        run in progress
//   Valid       one-cycle pulse, results final
//   MatchCount  permutations equal to BestCost
//   BestCost    optimum total
//   BestPerm    job of worker w at [w*IW +: IW]
//
// state    | meaning
// RUN_IDLE | waiting for Start
// RUN_SUM  | N cycles accumulating the current permutation's cost
// RUN_EVAL | compare sum with best, update best/count/perm
// RUN_STEP | generator runs PIVOT/SUCC/REVERSE to the next permutation
// RUN_DONE | Valid pulse, results visible
module jam_param
  import jam_pkg::*;
#(
  parameter int N  = JAM_N_DEF,
  parameter int CW = JAM_CW_DEF,
  parameter int IW = JAM_IW_DEF,
  parameter int SW = JAM_SW_DEF,
  parameter int MW = JAM_MW_DEF
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            Start,
  input  logic            MaxMode,
  output logic [IW-1:0]   W,
  output logic [IW-1:0]   J,
  input  logic [CW-1:0]   Cost,
  output logic            Busy,
  output logic            Valid,
  output logic [MW-1:0]   MatchCount,
  output logic [SW-1:0]   BestCost,
  output logic [N*IW-1:0] BestPerm
);

  if (N < 2 || N > 8) begin : g_bad_n
    $error("jam_param: N must be in 2..8");
  end
  if ((1 << IW) < N) begin : g_bad_iw
    $error("jam_param: IW too narrow for N");
  end
  if (SW < CW + IW) begin : g_bad_sw
    $error("jam_param: SW must be at least CW+IW");
  end
  if (MW < $clog2(factorial(N) + 1)) begin : g_bad_mw
    $error("jam_param: MW too narrow for N!");
  end

  localparam logic [IW-1:0] K_LAST = IW'(N - 1);

  run_state_t     state_q, state_d;
  logic [IW-1:0]  k_q, k_d;
  logic [SW-1:0]  sum_q, sum_d;
  logic [SW-1:0]  best_q, best_d;
  logic [MW-1:0]  cnt_q, cnt_d;
  logic [N*IW-1:0] bperm_q, bperm_d;
  logic           max_q, max_d;
  logic [MW-1:0]  out_cnt_q, out_cnt_d;
  logic [SW-1:0]  out_cost_q, out_cost_d;
  logic [N*IW-1:0] out_perm_q, out_perm_d;

  logic [N*IW-1:0] ident_flat;
  logic [N*IW-1:0] perm_flat;
  logic            gen_init, gen_step, gen_done, gen_last;
  logic [SW-1:0]   cost_ext;
  logic            improve, tie;

  for (genvar w = 0; w < N; w++) begin : g_ident
    assign ident_flat[w*IW +: IW] = IW'(w);
  end

  jam_perm_gen #(
    .N  (N),
    .IW (IW)
  ) u_perm_gen (
    .clk  (CLK),
    .rst  (RST),
    .init (gen_init),
    .step (gen_step),
    .perm (perm_flat),
    .done (gen_done),
    .last (gen_last)
  );

  always_comb begin
    W = (state_q == RUN_SUM) ? k_q : '0;
    J = perm_flat[int'(W)*IW +: IW];
  end

  assign cost_ext = {{(SW-CW){1'b0}}, Cost};
  assign improve  = max_q ? (sum_q > best_q) : (sum_q < best_q);
  assign tie      = (sum_q == best_q);

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    sum_d      = sum_q;
    best_d     = best_q;
    cnt_d      = cnt_q;
    bperm_d    = bperm_q;
    max_d      = max_q;
    out_cnt_d  = out_cnt_q;
    out_cost_d = out_cost_q;
    out_perm_d = out_perm_q;
    gen_init   = 1'b0;
    gen_step   = 1'b0;
    case (state_q)
      RUN_IDLE: begin
        if (Start) begin
          max_d    = MaxMode;
          // all-ones is unreachable as a sum, so the first permutation
          // always wins in min mode; in max mode a zero sum ties instead,
          // which is why bperm starts at identity
          best_d   = MaxMode ? '0 : '1;
          cnt_d    = '0;
          bperm_d  = ident_flat;
          k_d      = '0;
          gen_init = 1'b1;
          state_d  = RUN_SUM;
        end
      end
      RUN_SUM: begin
        sum_d = ((k_q == '0) ? '0 : sum_q) + cost_ext;
        if (k_q == K_LAST) begin
          k_d     = '0;
          state_d = RUN_EVAL;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      RUN_EVAL: begin
        if (improve) begin
          best_d  = sum_q;
          cnt_d   = MW'(1);
          bperm_d = perm_flat;
        end else if (tie) begin
          cnt_d = cnt_q + 1'b1;
        end
        gen_step = 1'b1;
        state_d  = RUN_STEP;
      end
      RUN_STEP: begin
        if (gen_done) begin
          if (gen_last) begin
            // load on entry so results are visible during the Valid cycle
            out_cnt_d  = cnt_q;
            out_cost_d = best_q;
            out_perm_d = bperm_q;
            state_d    = RUN_DONE;
          end else begin
            state_d = RUN_SUM;
          end
        end
      end
      RUN_DONE: state_d = RUN_IDLE;
      default:  state_d = RUN_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= RUN_IDLE;
      k_q        <= '0;
      sum_q      <= '0;
      best_q     <= '0;
      cnt_q      <= '0;
      bperm_q    <= ident_flat;
      max_q      <= 1'b0;
      out_cnt_q  <= '0;
      out_cost_q <= '0;
      out_perm_q <= ident_flat;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      sum_q      <= sum_d;
      best_q     <= best_d;
      cnt_q      <= cnt_d;
      bperm_q    <= bperm_d;
      max_q      <= max_d;
      out_cnt_q  <= out_cnt_d;
      out_cost_q <= out_cost_d;
      out_perm_q <= out_perm_d;
    end
  end

  assign Busy       = (state_q == RUN_SUM) || (state_q == RUN_EVAL) || (state_q == RUN_STEP);
  assign Valid      = (state_q == RUN_DONE);
  assign MatchCount = out_cnt_q;
  assign BestCost   = out_cost_q;
  assign BestPerm   = out_perm_q;

endmodule

// File: tb/tb_jam_param.sv
module tb_jam_param;

  localparam int N  = 5;
  localparam int CW = 7;
  localparam int IW = 3;
  localparam int SW = 10;
  localparam int MW = 7;
  localparam int RUN_LIMIT = 2100;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic            max_mode;
  logic [IW-1:0]   w_idx;
  logic [IW-1:0]   j_idx;
  logic [CW-1:0]   cost;
  logic            busy;
  logic            valid;
  logic [MW-1:0]   match_count;
  logic [SW-1:0]   best_cost;
  logic [N*IW-1:0] best_perm;

  logic [CW-1:0]   rom [8][8];
  logic [N*IW-1:0] ident;

  typedef struct {
    int              best;
    int              cnt;
    logic [N*IW-1:0] perm;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  logic prev_valid = 1'b0;

  always #5 clk = ~clk;

  assign cost = rom[w_idx][j_idx];

  jam_param #(
    .N  (N),
    .CW (CW),
    .IW (IW),
    .SW (SW),
    .MW (MW)
  ) dut (
    .CLK        (clk),
    .RST        (rst),
    .Start      (start),
    .MaxMode    (max_mode),
    .W          (w_idx),
    .J          (j_idx),
    .Cost       (cost),
    .Busy       (busy),
    .Valid      (valid),
    .MatchCount (match_count),
    .BestCost   (best_cost),
    .BestPerm   (best_perm)
  );

  task automatic chk(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Reference: walk every N-digit base-N number in increasing order (worker 0
  // most significant), keep only those with distinct digits, which yields the
  // permutations in lexicographic order.
  function automatic exp_t model(input bit mx);
    exp_t e;
    int   digits [N];
    int   c, sum, used;
    bit   ok;
    e.best = mx ? -1 : (1 << 30);
    e.cnt  = 0;
    e.perm = '0;
    for (int code = 0; code < N**N; code++) begin
      c = code;
      for (int k = N - 1; k >= 0; k--) begin
        digits[k] = c % N;
        c = c / N;
      end
      used = 0;
      ok   = 1'b1;
      for (int k = 0; k < N; k++) begin
        if (((used >> digits[k]) & 1) != 0) ok = 1'b0;
        used = used | (1 << digits[k]);
      end
      if (ok) begin
        sum = 0;
        for (int k = 0; k < N; k++) sum += int'(rom[k][digits[k]]);
        if (mx ? (sum > e.best) : (sum < e.best)) begin
          e.best = sum;
          e.cnt  = 1;
          for (int k = 0; k < N; k++) e.perm[k*IW +: IW] = IW'(digits[k]);
        end else if (sum == e.best) begin
          e.cnt++;
        end
      end
    end
    return e;
  endfunction

  // Monitor: every Valid pops one expected result.
  always @(negedge clk) begin
    exp_t e;
    if (valid) begin
      chk("valid_single_cycle", prev_valid, 0);
      chk("busy_low_at_valid", busy, 0);
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_valid actual=1 required=0");
      end else begin
        e = exp_q.pop_front();
        chk("best_cost", best_cost, e.best);
        chk("match_count", match_count, e.cnt);
        chk("best_perm", best_perm, e.perm);
      end
    end
    prev_valid = valid;
  end

  task automatic fill_const(input int v);
    for (int a = 0; a < 8; a++)
      for (int b = 0; b < 8; b++) rom[a][b] = CW'(v);
  endtask

  task automatic fill_diag();
    for (int a = 0; a < 8; a++)
      for (int b = 0; b < 8; b++) rom[a][b] = (a == b) ? CW'(0) : CW'(9);
  endtask

  task automatic fill_rand(input int maxv);
    for (int a = 0; a < 8; a++)
      for (int b = 0; b < 8; b++) rom[a][b] = CW'($urandom_range(maxv, 0));
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_w"}, w_idx, 0);
    chk({tag, "_j"}, j_idx, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_valid"}, valid, 0);
    chk({tag, "_match_count"}, match_count, 0);
    chk({tag, "_best_cost"}, best_cost, 0);
    chk({tag, "_best_perm"}, best_perm, ident);
  endtask

  task automatic wait_valid(input string tag);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < RUN_LIMIT; n++) begin
      @(negedge clk);
      if (valid) begin
        seen = 1'b1;
        break;
      end
    end
    chk({tag, "_run_completed"}, seen, 1);
  endtask

  task automatic run(input bit mx, input string tag);
    exp_q.push_back(model(mx));
    @(negedge clk);
    start    = 1'b1;
    max_mode = mx;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_busy_after_start"}, busy, 1);
    wait_valid(tag);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < N; k++) ident[k*IW +: IW] = IW'(k);
    rst      = 1'b1;
    start    = 1'b0;
    max_mode = 1'b0;
    fill_const(0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;

    fill_const(5);   run(1'b0, "const5_min");
    fill_diag();     run(1'b0, "diag_min");
    run(1'b1, "diag_max");
    fill_const(0);   run(1'b1, "zero_max");
    fill_const(127); run(1'b0, "full_min");
    for (int r = 0; r < 4; r++) begin
      fill_rand(127);
      run(1'b0, "rand_min");
      run(1'b1, "rand_max");
    end
    fill_rand(2);
    run(1'b0, "ties_min");
    run(1'b1, "ties_max");

    // Start pulses and MaxMode changes during a run must be ignored.
    fill_rand(127);
    exp_q.push_back(model(1'b0));
    @(negedge clk);
    start    = 1'b1;
    max_mode = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (4) begin
      repeat (7) @(negedge clk);
      start    = 1'b1;
      max_mode = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    max_mode = 1'b0;
    wait_valid("busy_start");
    repeat (20) @(negedge clk);
    chk("idle_after_ignored_start", busy, 0);

    // Reset in the middle of SUM: no result, then a clean rerun.
    @(negedge clk);
    start    = 1'b1;
    max_mode = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals("midrun_reset");
    rst = 1'b0;
    repeat (30) @(negedge clk);
    chk("no_busy_after_abort", busy, 0);
    run(1'b1, "after_reset_max");

    // Start held high: back-to-back runs, MaxMode switched between them.
    fill_rand(127);
    exp_q.push_back(model(1'b0));
    exp_q.push_back(model(1'b1));
    @(negedge clk);
    start    = 1'b1;
    max_mode = 1'b0;
    wait_valid("b2b_first");
    max_mode = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("b2b_restart_busy", busy, 1);
    start = 1'b0;
    wait_valid("b2b_second");

    repeat (10) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
